// File: rtl/control_muestreo.sv
// rtl/control_muestreo.sv - sample-rate scheduler for the ADC -> filter bank -> DAC chain
module control_muestreo #(
  parameter int DIV_MUESTREO = 2272,
  parameter int LAT_FILTRO   = 8,
  parameter int TIMEOUT_ADC  = 1024,
  parameter int CW           = 16
) (
  input  logic          clock_In,
  input  logic          Reset,
  input  logic          run,
  input  logic [1:0]    Filtro,
  input  logic          adc_done,
  input  logic          dac_busy,
  input  logic          clr_flags,
  output logic          adc_start,
  output logic          filt_load,
  output logic          dac_start,
  output logic [1:0]    sel_filtro,
  output logic          overrun,
  output logic          adc_timeout,
  output logic [CW-1:0] sample_count,
  output logic [CW-1:0] drop_count,
  output logic          busy
);

  localparam int TW = $clog2(DIV_MUESTREO);
  localparam int AW = $clog2(TIMEOUT_ADC);
  localparam int LW = $clog2(LAT_FILTRO + 1);

  typedef enum logic [2:0] {
    IDLE, WAIT_TICK, ADC_START, ADC_WAIT, FILT_LOAD, FILT_WAIT, DAC_WAIT, DAC_START
  } state_t;

  state_t        state, next_state;
  logic [TW-1:0] tick_cnt;
  logic [AW-1:0] to_cnt;
  logic [LW-1:0] lat_cnt;
  logic          tick, to_expired, lat_done, in_flight, drop, timeout_set;

  assign tick       = (state != IDLE) && (tick_cnt == TW'(DIV_MUESTREO - 1));
  assign to_expired = (to_cnt == AW'(TIMEOUT_ADC - 1));
  assign lat_done   = (lat_cnt == LW'(LAT_FILTRO - 1));
  assign in_flight  = (state != IDLE) && (state != WAIT_TICK);
  // A tick landing on a sample still in flight is discarded, never queued.
  assign drop       = tick && in_flight;

  always_ff @(posedge clock_In) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    timeout_set = 1'b0;
    unique case (state)
      IDLE:      if (run) next_state = WAIT_TICK;
      WAIT_TICK: begin
        if (!run)      next_state = IDLE;
        else if (tick) next_state = ADC_START;
      end
      ADC_START: next_state = ADC_WAIT;
      ADC_WAIT: begin
        if (adc_done) begin
          next_state = FILT_LOAD;
        end else if (to_expired) begin
          next_state  = WAIT_TICK;
          timeout_set = 1'b1;
        end
      end
      FILT_LOAD: next_state = FILT_WAIT;
      FILT_WAIT: if (lat_done) next_state = DAC_WAIT;
      DAC_WAIT:  if (!dac_busy) next_state = DAC_START;
      DAC_START: next_state = run ? WAIT_TICK : IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Sample-period divider; held at zero in IDLE so the first tick comes a full period after run.
  always_ff @(posedge clock_In) begin
    if (Reset || state == IDLE || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  always_ff @(posedge clock_In) begin
    if (Reset || state == ADC_START) begin
      to_cnt <= '0;
    end else if (state == ADC_WAIT) begin
      to_cnt <= to_cnt + AW'(1);
    end
  end

  always_ff @(posedge clock_In) begin
    if (Reset || state == FILT_LOAD) begin
      lat_cnt <= '0;
    end else if (state == FILT_WAIT) begin
      lat_cnt <= lat_cnt + LW'(1);
    end
  end

  // Outputs are decoded from next_state so each strobe is a flop aligned with its state.
  always_ff @(posedge clock_In) begin
    if (Reset) begin
      adc_start    <= 1'b0;
      filt_load    <= 1'b0;
      dac_start    <= 1'b0;
      busy         <= 1'b0;
      sel_filtro   <= 2'b00;
      overrun      <= 1'b0;
      adc_timeout  <= 1'b0;
      sample_count <= '0;
      drop_count   <= '0;
    end else begin
      adc_start <= (next_state == ADC_START);
      filt_load <= (next_state == FILT_LOAD);
      dac_start <= (next_state == DAC_START);
      busy      <= (next_state != IDLE) && (next_state != WAIT_TICK);
      if (state == FILT_LOAD) sel_filtro <= Filtro;
      if (next_state == DAC_START) sample_count <= sample_count + CW'(1);
      if (drop) drop_count <= drop_count + CW'(1);
      if (drop)           overrun <= 1'b1;
      else if (clr_flags) overrun <= 1'b0;
      if (timeout_set)    adc_timeout <= 1'b1;
      else if (clr_flags) adc_timeout <= 1'b0;
    end
  end

endmodule
